// File: rtl/core_msg_rx_pkg.sv
// rtl/core_msg_rx_pkg.sv - shared receiver state encodings and helpers
package core_msg_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SEL   = 2'd1,
    RX_R0    = 2'd2,
    RX_INSTR = 2'd3
  } rx_state_t;

  localparam int NUM_FLAGS = 4;

  function automatic int r0_word_count(input int data_size, input int bus_width);
    return data_size / bus_width;
  endfunction

  // True when more than one qualifier flag is raised in the same cycle.
  function automatic logic multi_flag(input logic [NUM_FLAGS-1:0] flags);
    return (flags & (flags - NUM_FLAGS'(1))) != '0;
  endfunction

endpackage

// File: rtl/core_msg_rx_instr_fifo.sv
// rtl/core_msg_rx_instr_fifo.sv - first-word-fall-through instruction FIFO
module core_msg_rx_instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/core_msg_rx.sv
// rtl/core_msg_rx.sv - core-side receiver for the scheduler->core message bus
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID      = 0,
  parameter int BUS_TO_CORE  = 16,
  parameter int R0_DATA_SIZE = 128,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUS_TO_CORE-1:0]  mess_to_core,
  input  logic                    core_mask_loading,
  input  logic                    r0_mask_loading,
  input  logic                    r0_loading,
  input  logic                    instr_loading,
  output logic                    core_reading,
  output logic                    core_ready,
  output logic [R0_DATA_SIZE-1:0] r0_data,
  output logic                    r0_valid,
  output logic [BUS_TO_CORE-1:0]  instr_out,
  output logic                    instr_valid,
  input  logic                    instr_pop,
  input  logic                    core_idle,
  output logic                    proto_err
);
  localparam int R0_WORDS = r0_word_count(R0_DATA_SIZE, BUS_TO_CORE);
  localparam int CNT_W    = $clog2(R0_WORDS + 1);
  localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  R0_LIMIT   = CNT_W'(R0_WORDS);
  localparam logic [FCNT_W-1:0] READ_LIMIT = FCNT_W'(FIFO_DEPTH - 2);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic              r0_sel;
  logic              my_bit;
  logic              any_flag;
  logic              flag_clash;
  logic              push;
  logic              err_set;
  logic              r0_pulse;
  logic              r0_wr;
  logic              sel_load;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign my_bit     = mess_to_core[CORE_ID];
  assign any_flag   = core_mask_loading | r0_mask_loading | r0_loading | instr_loading;
  assign flag_clash = multi_flag({core_mask_loading, r0_mask_loading, r0_loading, instr_loading});

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_set   = 1'b0;
    r0_pulse  = 1'b0;
    r0_wr     = 1'b0;
    sel_load  = 1'b0;
    if (flag_clash) begin
      err_set = 1'b1;
    end else begin
      case (state)
        RX_SEL: begin
          if (r0_mask_loading) begin
            sel_load  = 1'b1;
            state_nxt = RX_R0;
          end else if (any_flag) begin
            err_set   = 1'b1;
            state_nxt = RX_IDLE;
          end
        end
        RX_R0: begin
          r0_wr = r0_loading;
          if (r0_mask_loading) err_set = 1'b1;
          if (instr_loading) begin
            push      = 1'b1;
            state_nxt = RX_INSTR;
          end
          if (instr_loading || core_mask_loading) r0_pulse = r0_sel;
        end
        RX_INSTR: begin
          push = instr_loading;
          if (r0_loading || r0_mask_loading) err_set = 1'b1;
        end
        default: ;
      endcase
      // A mask word opens the next task from any state except SEL, closing any open stream.
      if (core_mask_loading && state != RX_SEL) begin
        state_nxt = my_bit ? RX_SEL : RX_IDLE;
        if (my_bit && !(fifo_empty && core_idle)) err_set = 1'b1;
      end
      if (push && fifo_full) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      word_cnt  <= '0;
      r0_sel    <= 1'b0;
      r0_data   <= '0;
      r0_valid  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      r0_valid <= r0_pulse;
      if (err_set) proto_err <= 1'b1;
      if (sel_load) begin
        r0_sel   <= my_bit;
        word_cnt <= '0;
      end else if (r0_wr && word_cnt < R0_LIMIT) begin
        if (r0_sel) r0_data[int'(word_cnt) * BUS_TO_CORE +: BUS_TO_CORE] <= mess_to_core;
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  core_msg_rx_instr_fifo #(
    .WIDTH (BUS_TO_CORE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mess_to_core),
    .pop       (instr_pop),
    .head      (instr_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Two free slots are kept because one word may already be in flight when this is sampled.
  assign core_reading = (fifo_count <= READ_LIMIT);
  assign instr_valid  = ~fifo_empty;
  assign core_ready   = (state == RX_IDLE) & fifo_empty & core_idle;

endmodule

// File: tb/tb_core_msg_rx.sv
// tb/tb_core_msg_rx.sv - randomized self-checking bench for core_msg_rx
module tb_core_msg_rx;
  localparam int CID   = 3;
  localparam int RW    = 8;
  localparam int DEPTH = 16;
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_CM   = 4'b1000;
  localparam logic [3:0] F_RM   = 4'b0100;
  localparam logic [3:0] F_RL   = 4'b0010;
  localparam logic [3:0] F_IL   = 4'b0001;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mess_to_core;
  logic         core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
  logic         core_reading, core_ready, r0_valid, instr_valid, proto_err;
  logic [127:0] r0_data;
  logic [15:0]  instr_out;
  logic         instr_pop, core_idle;

  always #5 clk = ~clk;

  core_msg_rx #(
    .CORE_ID(CID), .BUS_TO_CORE(16), .R0_DATA_SIZE(128), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .mess_to_core(mess_to_core),
    .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
    .r0_loading(r0_loading), .instr_loading(instr_loading),
    .core_reading(core_reading), .core_ready(core_ready), .r0_data(r0_data),
    .r0_valid(r0_valid), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_pop(instr_pop), .core_idle(core_idle), .proto_err(proto_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: task phase, r0 word array and an instruction queue.
  typedef enum {NO_TASK, AWAIT_R0MASK, LOAD_R0, STREAM} phase_t;
  phase_t      ph;
  bit          m_sel;
  int          m_cnt;
  logic [15:0] m_r0 [RW];
  logic [15:0] m_q [$];
  bit          m_err;
  bit          m_valid;

  function automatic logic [127:0] m_r0_flat();
    logic [127:0] r;
    for (int i = 0; i < RW; i++) r[i*16 +: 16] = m_r0[i];
    return r;
  endfunction

  function automatic void model_reset();
    ph = NO_TASK; m_sel = 0; m_cnt = 0; m_err = 0; m_valid = 0;
    for (int i = 0; i < RW; i++) m_r0[i] = '0;
    m_q.delete();
  endfunction

  function automatic void model_step(logic [3:0] f, logic [15:0] w, bit pop, bit idle);
    bit mine      = w[CID];
    bit was_full  = (m_q.size() == DEPTH);
    bit pre_empty = (m_q.size() == 0);
    bit do_push   = 0;
    m_valid = 0;
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if ($countones(f) > 1) begin
      m_err = 1;
    end else if (f == F_CM) begin
      if (ph == AWAIT_R0MASK) begin m_err = 1; ph = NO_TASK; end
      else begin
        if (ph == LOAD_R0 && m_sel) m_valid = 1;
        if (mine) begin
          if (!(pre_empty && idle)) m_err = 1;
          ph = AWAIT_R0MASK;
        end else ph = NO_TASK;
      end
    end else if (f == F_RM) begin
      if (ph == AWAIT_R0MASK) begin m_sel = mine; m_cnt = 0; ph = LOAD_R0; end
      else if (ph != NO_TASK) m_err = 1;
    end else if (f == F_RL) begin
      if (ph == AWAIT_R0MASK) begin m_err = 1; ph = NO_TASK; end
      else if (ph == LOAD_R0) begin
        if (m_cnt < RW) begin
          if (m_sel) m_r0[m_cnt] = w;
          m_cnt++;
        end
      end else if (ph == STREAM) m_err = 1;
    end else if (f == F_IL) begin
      if (ph == AWAIT_R0MASK) begin m_err = 1; ph = NO_TASK; end
      else if (ph == LOAD_R0) begin do_push = 1; m_valid = m_sel; ph = STREAM; end
      else if (ph == STREAM) do_push = 1;
    end
    if (do_push) begin
      if (was_full) m_err = 1;
      else m_q.push_back(w);
    end
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("r0_data", r0_data, m_r0_flat());
    chk("r0_valid", 128'(r0_valid), 128'(m_valid));
    chk("instr_valid", 128'(instr_valid), 128'(m_q.size() > 0));
    if (m_q.size() > 0) chk("instr_out", 128'(instr_out), 128'(m_q[0]));
    chk("core_reading", 128'(core_reading), 128'(m_q.size() <= DEPTH - 2));
    chk("core_ready", 128'(core_ready), 128'(ph == NO_TASK && m_q.size() == 0 && core_idle));
    chk("proto_err", 128'(proto_err), 128'(m_err));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic cyc(input logic [3:0] f, input logic [15:0] w, input bit pop, input bit idle);
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = f;
    mess_to_core = w;
    instr_pop    = pop;
    core_idle    = idle;
    @(posedge clk);
    model_step(f, w, pop, idle);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = F_NONE;
    instr_pop = 1'b0;
    core_idle = 1'b1;
    #2;
    model_reset();
    chk("rst_core_reading", 128'(core_reading), 128'(1));
    chk("rst_core_ready", 128'(core_ready), 128'(1));
    chk("rst_r0_data", r0_data, 128'(0));
    chk("rst_r0_valid", 128'(r0_valid), 128'(0));
    chk("rst_instr_valid", 128'(instr_valid), 128'(0));
    chk("rst_proto_err", 128'(proto_err), 128'(0));
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, ni;
    logic [127:0] t1_r0;
    reset = 1'b1;
    mess_to_core = '0;
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = F_NONE;
    instr_pop = 1'b0;
    core_idle = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Task for this core: full r0 payload then one instruction.
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    for (int k = 1; k <= RW; k++) cyc(F_RL, 16'(k * 16'h1111), 0, 1);
    cyc(F_IL, 16'hA001, 0, 0);
    t1_r0 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    chk("t1_r0_data", r0_data, t1_r0);
    chk("t1_r0_valid", 128'(r0_valid), 128'(1));
    chk("t1_instr_out", 128'(instr_out), 128'(16'hA001));
    chk("t1_core_ready", 128'(core_ready), 128'(0));
    cyc(F_NONE, 16'h0, 0, 1);
    chk("t1_r0_valid_pulse", 128'(r0_valid), 128'(0));
    cyc(F_NONE, 16'h0, 1, 1);

    // Task for another core is ignored entirely.
    cyc(F_CM, 16'h0004, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    for (int k = 0; k < 4; k++) cyc(F_RL, 16'hDEAD, 0, 1);
    cyc(F_IL, 16'hB002, 0, 1);
    chk("t2_core_ready", 128'(core_ready), 128'(1));
    chk("t2_instr_valid", 128'(instr_valid), 128'(0));
    chk("t2_proto_err", 128'(proto_err), 128'(0));

    // Our task with r0 not selected: excess r0 words, five instructions.
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0000, 0, 1);
    for (int k = 0; k < 13; k++) cyc(F_RL, 16'($urandom), 0, 1);
    for (int k = 0; k < 5; k++) cyc(F_IL, 16'hC000 + 16'(k), 0, 1);
    chk("t3_r0_kept", r0_data, t1_r0);
    cyc(F_CM, 16'h0000, 0, 1);
    for (int k = 0; k < 5; k++) cyc(F_NONE, 16'h0, 1, 1);
    chk("t3_drained", 128'(instr_valid), 128'(0));

    // FIFO fill: reading drops after the 15th word, the 17th overflows.
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      cyc(F_IL, 16'($urandom), 0, 1);
      if (i == 14) chk("t4_reading_14", 128'(core_reading), 128'(1));
      if (i == 15) chk("t4_reading_15", 128'(core_reading), 128'(0));
    end
    chk("t4_overflow_err", 128'(proto_err), 128'(1));
    for (int i = 0; i < DEPTH; i++) cyc(F_NONE, 16'h0, 1, 1);

    // Flag clash, then push and pop together.
    @(negedge clk);
    do_reset();
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    cyc(F_RL | F_IL, 16'h5555, 0, 1);
    chk("t5_clash_err", 128'(proto_err), 128'(1));
    cyc(F_IL, 16'hE000, 0, 1);
    for (int k = 1; k <= 3; k++) cyc(F_IL, 16'hE000 + 16'(k), 1, 1);
    chk("t5_pushpop_valid", 128'(instr_valid), 128'(1));
    cyc(F_NONE, 16'h0, 1, 1);
    chk("t5_pushpop_count", 128'(instr_valid), 128'(0));

    // Reset mid r0 load, then a clean task.
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    for (int k = 0; k < 3; k++) cyc(F_RL, 16'h7000 + 16'(k), 0, 1);
    do_reset();
    cyc(F_CM, 16'h0008, 0, 1);
    cyc(F_RM, 16'h0008, 0, 1);
    for (int k = 0; k < RW; k++) cyc(F_RL, 16'($urandom), 0, 1);
    cyc(F_IL, 16'h1234, 1, 1);
    cyc(F_CM, 16'h0000, 1, 1);

    // Randomized task streams against the model.
    @(negedge clk);
    do_reset();
    for (int t = 0; t < 30; t++) begin
      for (int d = 0; d < 40 && m_q.size() > 0; d++) cyc(F_NONE, 16'h0, 1, 1);
      cyc(F_CM, 16'($urandom) | (($urandom_range(0, 3) != 0) ? 16'h0008 : 16'h0000), 0, 1);
      cyc(F_RM, 16'($urandom), bit'($urandom_range(0, 1)), 1);
      nr = int'($urandom_range(0, 10));
      ni = int'($urandom_range(0, 6));
      for (int k = 0; k < nr; k++)
        cyc(F_RL, 16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 9) == 0) cyc(F_RL | F_IL, 16'($urandom), 0, 1);
      for (int k = 0; k < ni; k++)
        cyc(F_IL, 16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
